// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - serial multiply-accumulate neuron stage with 17-bit signed saturation
// Accumulates bias + sum(x*w) over N_INPUTS accepted beats; sum/out_valid update on the last beat.
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 17,
  parameter int BIAS_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIAS_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic              busy,
  output logic [OUT_W-1:0]  sum,
  output logic              out_valid
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 2;
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [OUT_W-1:0]         sum_q, sum_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;

  assign prod    = $signed(x) * $signed(w);
  assign acc_sum = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = acc_sum;
          count_d = count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            // Clamp only on the final beat; the accumulator itself is wide enough never to wrap.
            if (acc_sum > SAT_MAX)      sum_d = OUT_MAX;
            else if (acc_sum < SAT_MIN) sum_d = OUT_MIN;
            else                        sum_d = acc_sum[OUT_W-1:0];
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - scoreboard bench for neuron_mac with directed vectors
// Stimulus pushes hand-computed sums; a negedge monitor pops and compares on out_valid.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  w;
  logic        busy;
  logic [16:0] sum;
  logic        out_valid;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_q[$];
  logic signed [7:0] xv[4];
  logic signed [7:0] wv[4];

  neuron_mac #(.N_INPUTS(4), .DATA_W(8), .OUT_W(17), .BIAS_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .w(w), .busy(busy), .sum(sum), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: got sum %0d expected no output", $signed(sum));
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'($signed(sum)) != e) begin
          n_fail++;
          $display("FAIL sum: got %0d expected %0d", $signed(sum), e);
        end
      end
    end
  end

  task automatic set_vec(input int x0, x1, x2, x3, w0, w1, w2, w3);
    xv[0] = 8'(x0); xv[1] = 8'(x1); xv[2] = 8'(x2); xv[3] = 8'(x3);
    wv[0] = 8'(w0); wv[1] = 8'(w1); wv[2] = 8'(w2); wv[3] = 8'(w3);
  endtask

  // gap_len idle cycles inserted after beat index 1; noise asserts start/in_valid where they must be ignored
  task automatic run_eval(input int b, input int expv, input int gap_len, input bit noise);
    exp_q.push_back(expv);
    bias  = 16'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    bias  = 16'h7fff;
    check("busy_after_start", int'(busy), 1);
    check("in_ready_accum", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x = xv[i];
      w = wv[i];
      if (noise && i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      if (i == 1) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("in_ready_gap", int'(in_ready), 1);
          check("no_out_in_gap", int'(out_valid), 0);
        end
      end
      if (i < 3) check("no_early_out", int'(out_valid), 0);
    end
    check("out_valid_last_beat", int'(out_valid), 1);
    check("busy_done", int'(busy), 1);
    check("in_ready_done", int'(in_ready), 0);
    if (noise) begin
      start = 1'b1;
      in_valid = 1'b1;
    end
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("out_valid_drop", int'(out_valid), 0);
    check("busy_idle", int'(busy), 0);
    check("sum_held", int'($signed(sum)), expv);
    tick();
    check("still_idle", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; x = '0; w = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_sum", int'($signed(sum)), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);

    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    run_eval(10, 80, 0, 1'b0);
    run_eval(10, 80, 3, 1'b0);

    set_vec(-128, -128, -128, -128, 127, 127, 127, 127);
    run_eval(-1000, -65536, 0, 1'b0);
    set_vec(-128, -128, -128, -128, -128, -128, -128, -128);
    run_eval(0, 65535, 0, 1'b0);

    // in_valid while idle must not count as beats
    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    in_valid = 1'b1; x = 8'd50; w = 8'd50;
    tick(); tick(); tick();
    check("idle_in_valid_busy", int'(busy), 0);
    check("idle_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    run_eval(10, 80, 0, 1'b1);

    // reset after beat 2 aborts with no output
    bias = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x = xv[i]; w = wv[i];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_sum", int'($signed(sum)), 0);
    check("abort_out_valid", int'(out_valid), 0);
    tick();
    check("abort_no_out", int'(out_valid), 0);
    run_eval(10, 80, 0, 1'b0);

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
